// File: rtl/adc_sek_pkg.sv
// Shared types and helpers for the time-shared ADC sequencer (adc_sekvencer).

package adc_sek_pkg;

  localparam int unsigned ADC_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

  // Counter/index width for a range of n values, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic logic [ADC_W-1:0] rectify(input logic [ADC_W-1:0] x,
                                               input logic [ADC_W-1:0] off);
    return (x >= off) ? x - off : off - x;
  endfunction

endpackage

// File: rtl/vrsni_detektor.sv
// Per-channel peak hold: the first sample after a window restart loads directly.

module vrsni_detektor
  import adc_sek_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             restart,
  input  logic [ADC_W-1:0] d,
  output logic [ADC_W-1:0] peak
);

  logic [ADC_W-1:0] peak_q, peak_d;
  logic             first_q, first_d;

  always_comb begin
    peak_d  = peak_q;
    first_d = first_q;
    if (load) begin
      peak_d  = (first_q || (d > peak_q)) ? d : peak_q;
      first_d = 1'b0;
    end else if (restart) begin
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q  <= '0;
      first_q <= 1'b1;
    end else begin
      peak_q  <= peak_d;
      first_q <= first_d;
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/adc_sekvencer.sv
// Round-robin ADC scheduler with rectified per-channel peak publishing.
// Optional WAIT timeout with sticky error flag: define ADC_SEK_TIMEOUT_EN.

module adc_sekvencer
  import adc_sek_pkg::*;
#(
  parameter int unsigned      NCH     = 2,
  parameter int unsigned      PERIOD  = 1000,
  parameter int unsigned      WINDOW  = 64,
  parameter logic [ADC_W-1:0] OFFSET  = 12'd1900,
  parameter int unsigned      TIMEOUT = 200,
  localparam int unsigned     CH_W    = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             adc_start,
  output logic [CH_W-1:0]  adc_kanal,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_podatak,
  output logic [ADC_W-1:0] vrednost,
  output logic [CH_W-1:0]  vrednost_kanal,
  output logic             vrednost_valid,
  output logic             greska,
  input  logic             greska_clr
);

  localparam int unsigned     P_W     = ch_w(PERIOD);
  localparam int unsigned     W_W     = ch_w(WINDOW);
  localparam logic [P_W-1:0]  P_LAST  = P_W'(PERIOD - 1);
  localparam logic [W_W-1:0]  W_LAST  = W_W'(WINDOW - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

  state_e           state_q, state_d;
  logic [P_W-1:0]   tick_q, tick_d;
  logic [W_W-1:0]   win_q, win_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [ADC_W-1:0] vred_q, vred_d;
  logic [CH_W-1:0]  vk_q, vk_d;
  logic             tick, tmo, sample_ld, publish;
  logic [ADC_W-1:0] d, peak_sel;
  logic [ADC_W-1:0] peak [NCH];

  assign d = rectify(adc_podatak, OFFSET);

  // Slot timer free-runs while enabled; ticks that land outside IDLE are lost.
  always_comb begin
    tick   = en && (tick_q == P_LAST);
    tick_d = (!en || tick) ? '0 : tick_q + P_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    adc_start = 1'b0;
    sample_ld = 1'b0;
    unique case (state_q)
      IDLE:  if (tick) state_d = START;
      START: begin
        adc_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (adc_done) begin
          sample_ld = 1'b1;
          state_d   = DONE;
        end else if (tmo) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign publish = (state_q == DONE) && (win_q == W_LAST);

  always_comb begin
    ch_d   = ch_q;
    win_d  = win_q;
    vred_d = vred_q;
    vk_d   = vk_q;
    if (state_q == DONE) begin
      if (ch_q == CH_LAST) begin
        ch_d  = '0;
        win_d = (win_q == W_LAST) ? '0 : win_q + W_W'(1);
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
    if (publish) begin
      vred_d = peak_sel;
      vk_d   = ch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      win_q   <= '0;
      ch_q    <= '0;
      vred_q  <= '0;
      vk_q    <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      win_q   <= win_d;
      ch_q    <= ch_d;
      vred_q  <= vred_d;
      vk_q    <= vk_d;
    end
  end

`ifdef ADC_SEK_TIMEOUT_EN
  localparam int unsigned    T_W    = ch_w(TIMEOUT);
  localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

  logic [T_W-1:0] wait_q, wait_d;
  logic           greska_q, greska_d;

  // A timed-out conversion still counts as a sample so windows keep cadence.
  always_comb begin
    tmo      = (state_q == WAIT) && !adc_done && (wait_q == T_LAST);
    wait_d   = (state_q == WAIT) ? wait_q + T_W'(1) : '0;
    greska_d = tmo ? 1'b1 : (greska_clr ? 1'b0 : greska_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= '0;
      greska_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      greska_q <= greska_d;
    end
  end

  assign greska = greska_q;
`else
  logic unused_clr;
  assign tmo        = 1'b0;
  assign greska     = 1'b0;
  assign unused_clr = greska_clr | (TIMEOUT == 0);
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_det
    vrsni_detektor u_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (sample_ld && (ch_q == CH_W'(i))),
      .restart (publish && (ch_q == CH_W'(i))),
      .d       (d),
      .peak    (peak[i])
    );
  end

  assign peak_sel = peak[ch_q];

  // The fresh peak is shown in the strobe cycle itself, then held.
  assign adc_kanal      = ch_q;
  assign vrednost_valid = publish;
  assign vrednost       = publish ? peak_sel : vred_q;
  assign vrednost_kanal = publish ? ch_q : vk_q;

endmodule

// File: tb/tb_adc_sekvencer.sv
// Randomized self-checking bench for adc_sekvencer against a sample-level peak model.

module tb_adc_sekvencer;

  localparam int NCH     = 2;
  localparam int PERIOD  = 10;
  localparam int WINDOW  = 4;
  localparam int TIMEOUT = 5;

  localparam int M_NORM  = 0;
  localparam int M_TO    = 1;
  localparam int M_TOCLR = 2;
  localparam int M_ENOFF = 3;
  localparam int M_RST   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        adc_done = 1'b0;
  logic        greska_clr = 1'b0;
  logic [11:0] adc_podatak = '0;
  logic        adc_start, vrednost_valid, greska;
  logic        adc_kanal, vrednost_kanal;
  logic [11:0] vrednost;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_start = 0;

  int unsigned m_peak [NCH];
  bit          m_fresh [NCH];
  int unsigned m_cnt [NCH];
  int unsigned m_total;
  int unsigned m_vred;
  int unsigned m_vk;

  adc_sekvencer #(
    .NCH     (NCH),
    .PERIOD  (PERIOD),
    .WINDOW  (WINDOW),
    .OFFSET  (12'd1900),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .adc_start      (adc_start),
    .adc_kanal      (adc_kanal),
    .adc_done       (adc_done),
    .adc_podatak    (adc_podatak),
    .vrednost       (vrednost),
    .vrednost_kanal (vrednost_kanal),
    .vrednost_valid (vrednost_valid),
    .greska         (greska),
    .greska_clr     (greska_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned rect(input int unsigned v);
    int s;
    s = int'(v) - 1900;
    return (s < 0) ? -s : s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_peak[i]  = 0;
      m_fresh[i] = 1'b1;
      m_cnt[i]   = 0;
    end
    m_total = 0;
    m_vred  = 0;
    m_vk    = 0;
  endtask

  // One scheduled conversion on channel ch; have=0 means the sample was lost.
  task automatic model_sample(input int ch, input bit have, input int unsigned v,
                              output bit pub);
    int unsigned dv;
    if (have) begin
      dv = rect(v);
      m_peak[ch]  = (m_fresh[ch] || dv > m_peak[ch]) ? dv : m_peak[ch];
      m_fresh[ch] = 1'b0;
    end
    m_cnt[ch]++;
    m_total++;
    pub = (m_cnt[ch] % WINDOW) == 0;
    if (pub) begin
      m_vred      = m_peak[ch];
      m_vk        = ch;
      m_fresh[ch] = 1'b1;
    end
  endtask

  task automatic slot(input int mode, input logic [11:0] val, input int exp_gap);
    int n = 0;
    int ch;
    bit pub = 1'b0;
    while (adc_start !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", adc_start, 1);
    if (adc_start !== 1'b1) return;
    ch = m_total % NCH;
    check_eq("start_kanal", adc_kanal, ch);
    if (exp_gap > 0) check_eq("start_gap", cyc - last_start, exp_gap);
    last_start = cyc;
    @(negedge clk);
    check_eq("start_width", adc_start, 0);
    if (mode == M_ENOFF) en = 1'b0;
    if (mode == M_RST) begin
      rst_n = 1'b0;
      #1;
      check_eq("rst_start", adc_start, 0);
      check_eq("rst_vrednost", vrednost, 0);
      check_eq("rst_vkanal", vrednost_kanal, 0);
      check_eq("rst_kanal", adc_kanal, 0);
      check_eq("rst_greska", greska, 0);
      @(negedge clk);
      rst_n = 1'b1;
      last_start = cyc;
      adc_done = 1'b1;
      adc_podatak = val;
      @(negedge clk);
      adc_done = 1'b0;
      model_reset();
      check_eq("late_done_valid", vrednost_valid, 0);
      check_eq("late_done_vred", vrednost, 0);
      check_eq("late_done_start", adc_start, 0);
      return;
    end
    if (mode == M_TO || mode == M_TOCLR) begin
`ifdef ADC_SEK_TIMEOUT_EN
      repeat (3) @(negedge clk);
      check_eq("greska_pre", greska, 0);
      @(negedge clk);
      check_eq("greska_wait", greska, 0);
      if (mode == M_TOCLR) greska_clr = 1'b1;
      @(negedge clk);
      greska_clr = 1'b0;
      check_eq("greska_set", greska, 1);
      model_sample(ch, 1'b0, 0, pub);
`else
      repeat (20) @(negedge clk);
      check_eq("hold_greska", greska, 0);
      check_eq("hold_start", adc_start, 0);
      adc_done = 1'b1;
      adc_podatak = val;
      @(negedge clk);
      adc_done = 1'b0;
      model_sample(ch, 1'b1, val, pub);
`endif
    end else begin
      @(negedge clk);
      adc_done = 1'b1;
      adc_podatak = val;
      @(negedge clk);
      adc_done = 1'b0;
      adc_podatak = 12'($urandom);
      model_sample(ch, 1'b1, val, pub);
    end
    check_eq("valid", vrednost_valid, pub);
    check_eq("vrednost", vrednost, m_vred);
    check_eq("vkanal", vrednost_kanal, m_vk);
    @(negedge clk);
    check_eq("valid_width", vrednost_valid, 0);
  endtask

  initial begin
    logic [11:0] seq1 [8];
    logic [11:0] seq2 [8];
    int starts;
    seq1 = '{12'd2000, 12'd1900, 12'd1800, 12'd1900, 12'd2300, 12'd1900, 12'd1900, 12'd1900};
    seq2 = '{12'd1950, 12'd1900, 12'd1900, 12'd1900, 12'd1900, 12'd1900, 12'd1900, 12'd1900};
    model_reset();
    rst_n = 1'b0;
    en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("reset_start", adc_start, 0);
      check_eq("reset_valid", vrednost_valid, 0);
      check_eq("reset_vrednost", vrednost, 0);
    end
    rst_n = 1'b1;
    last_start = cyc;

    // Known peaks, then a restarted window, then random samples.
    for (int i = 0; i < 8; i++) slot(M_NORM, seq1[i], PERIOD);
    for (int i = 0; i < 8; i++) slot(M_NORM, seq2[i], PERIOD);
    for (int i = 0; i < 16; i++) slot(M_NORM, 12'($urandom_range(0, 4095)), PERIOD);

    slot(M_TO, 12'($urandom_range(0, 4095)), PERIOD);
    slot(M_NORM, 12'($urandom_range(0, 4095)), 0);
    greska_clr = 1'b1;
    @(negedge clk);
    greska_clr = 1'b0;
    check_eq("greska_clr", greska, 0);
    slot(M_TOCLR, 12'($urandom_range(0, 4095)), 0);
    for (int i = 0; i < 5; i++) slot(M_NORM, 12'($urandom_range(0, 4095)), 0);

    slot(M_ENOFF, 12'($urandom_range(0, 4095)), 0);
    starts = 0;
    repeat (50) begin
      @(negedge clk);
      if (adc_start === 1'b1) starts++;
    end
    check_eq("enoff_starts", starts, 0);
    en = 1'b1;
    last_start = cyc;
    for (int i = 0; i < 7; i++) slot(M_NORM, 12'($urandom_range(0, 4095)), PERIOD);

    slot(M_RST, 12'($urandom_range(0, 4095)), 0);
    for (int i = 0; i < 10; i++) slot(M_NORM, 12'($urandom_range(0, 4095)), PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
